// File: rtl/nor_cmd_seq_if.sv
// nor_cmd_seq_if
//   Wishbone write-path bundle between the NOR command sequencer (master)
//   and nor_bus (slave).
//
//   Parameters:
//     ADDRBITS  NOR word-address width
//     DATABITS  NOR data width
//
//   Signals:
//     cyc, stb, we  master bus controls
//     adr, dat      master address / write data
//     ack, stall    slave responses
//
//   Modports: master (sequencer side), slave (nor_bus side).
interface nor_cmd_seq_if #(
  parameter int ADDRBITS = 26,
  parameter int DATABITS = 16
) ();

  logic                cyc;
  logic                stb;
  logic                we;
  logic [ADDRBITS-1:0] adr;
  logic [DATABITS-1:0] dat;
  logic                ack;
  logic                stall;

  modport master (
    output cyc, stb, we, adr, dat,
    input  ack, stall
  );

  modport slave (
    input  cyc, stb, we, adr, dat,
    output ack, stall
  );

endinterface

// File: rtl/nor_cmd_seq.sv
// nor_cmd_seq
//   Expands high-level NOR flash operations (read/reset, program word,
//   sector erase, chip erase) into JEDEC unlock/command write sequences,
//   issues them as Wishbone single writes, then polls RY/BY# until the
//   embedded operation finishes.
//
//   Ports:
//     wb_clk_i     clock
//     wb_rst_ni    asynchronous active-low reset
//     cmd_op_i     00 READ_RESET, 01 PROGRAM, 10 SECTOR_ERASE, 11 CHIP_ERASE
//     cmd_addr_i   program / sector / reset address
//     cmd_data_i   program data
//     cmd_valid_i  command request; accepted with cmd_ready_o
//     cmd_ready_o  idle, able to accept a command
//     done_o       one-cycle completion pulse
//     err_o        RY timeout flag, valid with done_o
//     busy_o       sequence in progress (inverse of cmd_ready_o)
//     wbm          Wishbone master modport (nor_cmd_seq_if.master)
//     nor_ry_i     flash RY/BY#, 1 = ready
//
//   Configuration macro NOR_CMD_SEQ_TIMEOUT_EN:
//     defined   - POLL is bounded by TIMEOUT_CYCLES; on expiry a reset (F0)
//                 write is issued and done_o is reported with err_o = 1.
//     undefined - POLL waits for RY indefinitely and err_o is tied to 0.
module nor_cmd_seq #(
  parameter int          ADDRBITS       = 26,
  parameter int          DATABITS       = 16,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic [1:0]          cmd_op_i,
  input  logic [ADDRBITS-1:0] cmd_addr_i,
  input  logic [DATABITS-1:0] cmd_data_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  output logic                done_o,
  output logic                err_o,
  output logic                busy_o,
  nor_cmd_seq_if.master       wbm,
  input  logic                nor_ry_i
);

  localparam logic [1:0] OP_READ_RESET   = 2'b00;
  localparam logic [1:0] OP_PROGRAM      = 2'b01;
  localparam logic [1:0] OP_SECTOR_ERASE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_SETTLE,
    S_POLL,
`ifdef NOR_CMD_SEQ_TIMEOUT_EN
    S_ABORT,
`endif
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [ADDRBITS-1:0] caddr_q, caddr_d;
  logic [DATABITS-1:0] cdata_q, cdata_d;
  logic [2:0]          step_q, step_d;
  logic                cyc_q, cyc_d;
  logic                stb_q, stb_d;
  logic                we_q, we_d;
  logic [ADDRBITS-1:0] adr_q, adr_d;
  logic [DATABITS-1:0] dat_q, dat_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [31:0]         settle_q, settle_d;
  logic                go_done;
`ifdef NOR_CMD_SEQ_TIMEOUT_EN
  logic [31:0]         tout_q, tout_d;
  logic                abort_q, abort_d;
  logic                err_q, err_d;
`else
  logic                unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Saturating increment shared by the settle and timeout counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Index of the final write in each operation's sequence.
  function automatic logic [2:0] last_step(input logic [1:0] op);
    case (op)
      OP_READ_RESET: return 3'd0;
      OP_PROGRAM:    return 3'd3;
      default:       return 3'd5;
    endcase
  endfunction

  // Write address of a given step; erases share the six-write unlock form.
  function automatic logic [ADDRBITS-1:0] step_adr(input logic [1:0] op,
                                                   input logic [2:0] step,
                                                   input logic [ADDRBITS-1:0] ca);
    logic [ADDRBITS-1:0] a555;
    logic [ADDRBITS-1:0] a2aa;
    a555 = ADDRBITS'(12'h555);
    a2aa = ADDRBITS'(12'h2AA);
    case (op)
      OP_READ_RESET: return ca;
      OP_PROGRAM: begin
        case (step)
          3'd1:    return a2aa;
          3'd3:    return ca;
          default: return a555;
        endcase
      end
      default: begin
        case (step)
          3'd1, 3'd4: return a2aa;
          3'd5:       return (op == OP_SECTOR_ERASE) ? ca : a555;
          default:    return a555;
        endcase
      end
    endcase
  endfunction

  // Write data of a given step.
  function automatic logic [DATABITS-1:0] step_dat(input logic [1:0] op,
                                                   input logic [2:0] step,
                                                   input logic [DATABITS-1:0] cd);
    case (op)
      OP_READ_RESET: return DATABITS'(8'hF0);
      OP_PROGRAM: begin
        case (step)
          3'd0:    return DATABITS'(8'hAA);
          3'd1:    return DATABITS'(8'h55);
          3'd2:    return DATABITS'(8'hA0);
          default: return cd;
        endcase
      end
      default: begin
        case (step)
          3'd0, 3'd3: return DATABITS'(8'hAA);
          3'd1, 3'd4: return DATABITS'(8'h55);
          3'd2:       return DATABITS'(8'h80);
          default:    return (op == OP_SECTOR_ERASE) ? DATABITS'(8'h30) : DATABITS'(8'h10);
        endcase
      end
    endcase
  endfunction

  // State and every output live in flops; the async reset puts the bus
  // idle immediately without issuing any recovery write.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      caddr_q  <= '0;
      cdata_q  <= '0;
      step_q   <= 3'd0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      settle_q <= 32'd0;
`ifdef NOR_CMD_SEQ_TIMEOUT_EN
      tout_q   <= 32'd0;
      abort_q  <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      caddr_q  <= caddr_d;
      cdata_q  <= cdata_d;
      step_q   <= step_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      settle_q <= settle_d;
`ifdef NOR_CMD_SEQ_TIMEOUT_EN
      tout_q   <= tout_d;
      abort_q  <= abort_d;
      err_q    <= err_d;
`endif
    end
  end

  // Next-state and next-output logic. cyc is raised together with the first
  // stb and held through every inter-step gap, since nor_bus flushes its
  // FIFO whenever cyc drops; it only falls before SETTLE or on completion.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    caddr_d  = caddr_q;
    cdata_d  = cdata_q;
    step_d   = step_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    we_d     = we_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    settle_d = settle_q;
    go_done  = 1'b0;
`ifdef NOR_CMD_SEQ_TIMEOUT_EN
    tout_d   = tout_q;
    abort_d  = abort_q;
    err_d    = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && ready_q) begin
          state_d = S_ISSUE;
          op_d    = cmd_op_i;
          caddr_d = cmd_addr_i;
          cdata_d = cmd_data_i;
          step_d  = 3'd0;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          adr_d   = step_adr(cmd_op_i, 3'd0, cmd_addr_i);
          dat_d   = step_dat(cmd_op_i, 3'd0, cmd_data_i);
          ready_d = 1'b0;
          busy_d  = 1'b1;
`ifdef NOR_CMD_SEQ_TIMEOUT_EN
          abort_d = 1'b0;
          err_d   = 1'b0;
`endif
        end
      end

      S_ISSUE: begin
        if (stb_q && !wbm.stall) begin
          stb_d   = 1'b0;
          state_d = S_WAIT_ACK;
        end
      end

      S_WAIT_ACK: begin
        if (wbm.ack) begin
`ifdef NOR_CMD_SEQ_TIMEOUT_EN
          if (abort_q) begin
            go_done = 1'b1;
          end else
`endif
          if (step_q != last_step(op_q)) begin
            step_d  = step_q + 3'd1;
            state_d = S_ISSUE;
            stb_d   = 1'b1;
            adr_d   = step_adr(op_q, step_q + 3'd1, caddr_q);
            dat_d   = step_dat(op_q, step_q + 3'd1, cdata_q);
          end else if (op_q == OP_READ_RESET) begin
            go_done = 1'b1;
          end else begin
            state_d  = S_SETTLE;
            cyc_d    = 1'b0;
            we_d     = 1'b0;
            settle_d = 32'd0;
`ifdef NOR_CMD_SEQ_TIMEOUT_EN
            tout_d   = 32'd0;
`endif
          end
        end
      end

      // Give the flash time to pull RY low before trusting it.
      S_SETTLE: begin
        settle_d = sat_inc(settle_q);
        if (settle_d >= SETTLE_CYCLES) begin
          state_d = S_POLL;
        end
      end

      // RY has priority over an expiring timeout on the same cycle.
      S_POLL: begin
        if (nor_ry_i) begin
          go_done = 1'b1;
        end
`ifdef NOR_CMD_SEQ_TIMEOUT_EN
        else begin
          tout_d = sat_inc(tout_q);
          if (tout_d >= TIMEOUT_CYCLES) begin
            state_d = S_ABORT;
            abort_d = 1'b1;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = 1'b1;
            adr_d   = caddr_q;
            dat_d   = DATABITS'(8'hF0);
          end
        end
`endif
      end

`ifdef NOR_CMD_SEQ_TIMEOUT_EN
      // Recovery write to return the flash to read mode; completion is
      // handled by WAIT_ACK through the abort flag.
      S_ABORT: begin
        if (stb_q && !wbm.stall) begin
          stb_d   = 1'b0;
          state_d = S_WAIT_ACK;
        end
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
`ifdef NOR_CMD_SEQ_TIMEOUT_EN
        err_d   = 1'b0;
`endif
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (go_done) begin
      state_d = S_DONE;
      cyc_d   = 1'b0;
      stb_d   = 1'b0;
      we_d    = 1'b0;
      done_d  = 1'b1;
`ifdef NOR_CMD_SEQ_TIMEOUT_EN
      err_d   = abort_q;
`endif
    end
  end

  assign cmd_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
`ifdef NOR_CMD_SEQ_TIMEOUT_EN
  assign err_o       = err_q;
`else
  assign err_o       = 1'b0;
`endif
  assign wbm.cyc     = cyc_q;
  assign wbm.stb     = stb_q;
  assign wbm.we      = we_q;
  assign wbm.adr     = adr_q;
  assign wbm.dat     = dat_q;

endmodule

// File: tb/tb_nor_cmd_seq.sv
// tb_nor_cmd_seq
//   Scoreboard bench for nor_cmd_seq. Directed commands push their expected
//   Wishbone writes and completion flags into queues; a negedge monitor that
//   also models nor_bus (3-cycle ack, optional stall) pops and compares.
module tb_nor_cmd_seq;

  typedef struct {
    logic [25:0] adr;
    logic [15:0] dat;
    bit          cont;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [25:0] cmd_addr = '0;
  logic [15:0] cmd_data = '0;
  logic        cmd_valid = 1'b0;
  logic        ry = 1'b1;
  logic        cmd_ready_o, done_o, err_o, busy_o;

  wr_t  exp_wr[$];
  bit   exp_done[$];
  int   num_checks = 0;
  int   num_errors = 0;
  int   acc_in_cmd = 0;
  int   ack_cnt = 0;
  int   stall_step = -1;
  int   stall_left = 0;
  int   done_seen = 0;
  bit   cyc_low_seen = 1'b1;
  bit   ready_chk = 1'b0;
  bit   cap_valid = 1'b0;
  logic [25:0] cap_adr;
  logic [15:0] cap_dat;

  nor_cmd_seq_if #(.ADDRBITS(26), .DATABITS(16)) wb ();

  nor_cmd_seq #(
    .ADDRBITS(26),
    .DATABITS(16),
    .SETTLE_CYCLES(16),
    .TIMEOUT_CYCLES(32'd100)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_ni(rst_n),
    .cmd_op_i(cmd_op),
    .cmd_addr_i(cmd_addr),
    .cmd_data_i(cmd_data),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready_o),
    .done_o(done_o),
    .err_o(err_o),
    .busy_o(busy_o),
    .wbm(wb.master),
    .nor_ry_i(ry)
  );

  always #5 clk = ~clk;

  initial begin
    wb.ack   = 1'b0;
    wb.stall = 1'b0;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expectWrite(input logic [25:0] adr, input logic [15:0] dat, input bit cont);
    wr_t w;
    w.adr = adr;
    w.dat = dat;
    w.cont = cont;
    exp_wr.push_back(w);
  endtask

  task automatic checkResetValues();
    checkOutput("rst_ready", cmd_ready_o, 1);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_err", err_o, 0);
    checkOutput("rst_cyc", wb.cyc, 0);
    checkOutput("rst_stb", wb.stb, 0);
    checkOutput("rst_we", wb.we, 0);
    checkOutput("rst_adr", 32'(wb.adr), 0);
    checkOutput("rst_dat", 32'(wb.dat), 0);
  endtask

  // Waits for ready, presents one command for one cycle, then scrambles the
  // command inputs so any failure to latch them shows up in the writes.
  task automatic applyStimulus(input logic [1:0] op, input logic [25:0] addr, input logic [15:0] data);
    int guard = 0;
    @(negedge clk); #1;
    while (!cmd_ready_o && guard < 200) begin
      @(negedge clk); #1;
      guard++;
    end
    checkOutput("ready_before_cmd", cmd_ready_o, 1);
    acc_in_cmd = 0;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_valid = 1'b1;
    @(negedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    cmd_addr  = ~addr;
    cmd_data  = ~data;
    checkOutput("stb_after_accept", wb.stb, 1);
    checkOutput("busy_after_accept", busy_o, 1);
    checkOutput("ready_after_accept", cmd_ready_o, 0);
  endtask

  task automatic waitIdle(input int budget);
    int g = 0;
    while ((exp_wr.size() != 0 || exp_done.size() != 0 || !cmd_ready_o) && g < budget) begin
      @(negedge clk); #1;
      g++;
    end
    checkOutput("pending_writes", exp_wr.size(), 0);
    checkOutput("pending_done", exp_done.size(), 0);
    checkOutput("idle_ready", cmd_ready_o, 1);
  endtask

  // nor_bus model plus scoreboard monitor: ack, stall and all output
  // sampling happen on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      wb.ack       = 1'b0;
      wb.stall     = 1'b0;
      ack_cnt      = 0;
      cyc_low_seen = 1'b1;
      cap_valid    = 1'b0;
      ready_chk    = 1'b0;
    end else begin
      if (!wb.cyc) cyc_low_seen = 1'b1;
      wb.ack = 1'b0;
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) wb.ack = 1'b1;
      end
      wb.stall = 1'b0;
      if (wb.stb && acc_in_cmd == stall_step && stall_left > 0) begin
        wb.stall = 1'b1;
        stall_left--;
        if (!cap_valid) begin
          cap_adr   = wb.adr;
          cap_dat   = wb.dat;
          cap_valid = 1'b1;
        end else begin
          checkOutput("stall_adr_stable", 32'(wb.adr), 32'(cap_adr));
          checkOutput("stall_dat_stable", 32'(wb.dat), 32'(cap_dat));
        end
      end
      if (wb.stb && !wb.stall) begin
        checkOutput("write_expected", exp_wr.size() != 0, 1);
        checkOutput("write_we", wb.we, 1);
        checkOutput("write_cyc", wb.cyc, 1);
        if (exp_wr.size() != 0) begin
          wr_t e;
          e = exp_wr.pop_front();
          checkOutput("write_adr", 32'(wb.adr), 32'(e.adr));
          checkOutput("write_dat", 32'(wb.dat), 32'(e.dat));
          checkOutput("cyc_gap", cyc_low_seen, !e.cont);
        end
        ack_cnt      = 3;
        acc_in_cmd++;
        cyc_low_seen = 1'b0;
        cap_valid    = 1'b0;
      end
      if (ready_chk) begin
        checkOutput("ready_after_done", cmd_ready_o, 1);
        checkOutput("busy_after_done", busy_o, 0);
        ready_chk = 1'b0;
      end
      if (done_o) begin
        done_seen++;
        checkOutput("done_expected", exp_done.size() != 0, 1);
        if (exp_done.size() != 0) begin
          bit e;
          e = exp_done.pop_front();
          checkOutput("done_err", err_o, e);
        end
        checkOutput("ready_in_done", cmd_ready_o, 0);
        checkOutput("writes_before_done", exp_wr.size(), 0);
        ready_chk = 1'b1;
      end
    end
  end

  initial begin
    int g;
    int expected_dones;
    expected_dones = 0;

    repeat (3) @(negedge clk);
    #1;
    checkResetValues();
    @(negedge clk); #1;
    rst_n = 1'b1;

    // PROGRAM 0x1234/BEEF, RY low for 40 cycles after accept.
    $display("[TB] program word");
    ry = 1'b0;
    expectWrite(26'h555, 16'h00AA, 0);
    expectWrite(26'h2AA, 16'h0055, 1);
    expectWrite(26'h555, 16'h00A0, 1);
    expectWrite(26'h0001234, 16'hBEEF, 1);
    exp_done.push_back(1'b0);
    expected_dones++;
    applyStimulus(2'b01, 26'h0001234, 16'hBEEF);
    repeat (40) @(negedge clk);
    #1;
    checkOutput("program_waits_for_ry", exp_done.size(), 1);
    ry = 1'b1;
    waitIdle(100);

    // SECTOR_ERASE 0x0100000, RY already high.
    $display("[TB] sector erase");
    expectWrite(26'h555, 16'h00AA, 0);
    expectWrite(26'h2AA, 16'h0055, 1);
    expectWrite(26'h555, 16'h0080, 1);
    expectWrite(26'h555, 16'h00AA, 1);
    expectWrite(26'h2AA, 16'h0055, 1);
    expectWrite(26'h0100000, 16'h0030, 1);
    exp_done.push_back(1'b0);
    expected_dones++;
    applyStimulus(2'b10, 26'h0100000, 16'h0000);
    waitIdle(200);

    // PROGRAM with stall held for 5 cycles on step 2.
    $display("[TB] stall on step 2");
    stall_step = 2;
    stall_left = 5;
    expectWrite(26'h555, 16'h00AA, 0);
    expectWrite(26'h2AA, 16'h0055, 1);
    expectWrite(26'h555, 16'h00A0, 1);
    expectWrite(26'h0000ABC, 16'h1357, 1);
    exp_done.push_back(1'b0);
    expected_dones++;
    applyStimulus(2'b01, 26'h0000ABC, 16'h1357);
    waitIdle(200);
    checkOutput("stall_consumed", stall_left, 0);
    stall_step = -1;

    // CHIP_ERASE with a second request during POLL, which must be ignored.
    $display("[TB] chip erase with extra request");
    ry = 1'b0;
    expectWrite(26'h555, 16'h00AA, 0);
    expectWrite(26'h2AA, 16'h0055, 1);
    expectWrite(26'h555, 16'h0080, 1);
    expectWrite(26'h555, 16'h00AA, 1);
    expectWrite(26'h2AA, 16'h0055, 1);
    expectWrite(26'h555, 16'h0010, 1);
    exp_done.push_back(1'b0);
    expected_dones++;
    applyStimulus(2'b11, 26'h0000000, 16'h0000);
    g = 0;
    while (exp_wr.size() != 0 && g < 200) begin
      @(negedge clk); #1;
      g++;
    end
    checkOutput("chip_writes_issued", exp_wr.size(), 0);
    repeat (25) @(negedge clk);
    #1;
    checkOutput("ready_during_poll", cmd_ready_o, 0);
    cmd_op    = 2'b00;
    cmd_addr  = 26'h0000099;
    cmd_valid = 1'b1;
    @(negedge clk); #1;
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    ry = 1'b1;
    waitIdle(100);
    repeat (20) @(negedge clk);
    #1;

`ifdef NOR_CMD_SEQ_TIMEOUT_EN
    // RY stuck low: timeout leads to an F0 recovery write and err.
    $display("[TB] timeout abort");
    ry = 1'b0;
    expectWrite(26'h555, 16'h00AA, 0);
    expectWrite(26'h2AA, 16'h0055, 1);
    expectWrite(26'h555, 16'h00A0, 1);
    expectWrite(26'h0000777, 16'h0042, 1);
    expectWrite(26'h0000777, 16'h00F0, 0);
    exp_done.push_back(1'b1);
    expected_dones++;
    applyStimulus(2'b01, 26'h0000777, 16'h0042);
    waitIdle(600);
`endif

    // Reset asserted during WAIT_ACK of CHIP_ERASE step 3.
    $display("[TB] reset mid-sequence");
    ry = 1'b0;
    expectWrite(26'h555, 16'h00AA, 0);
    expectWrite(26'h2AA, 16'h0055, 1);
    expectWrite(26'h555, 16'h0080, 1);
    expectWrite(26'h555, 16'h00AA, 1);
    applyStimulus(2'b11, 26'h0000000, 16'h0000);
    g = 0;
    while (acc_in_cmd < 4 && g < 200) begin
      @(negedge clk); #1;
      g++;
    end
    checkOutput("reached_step3", acc_in_cmd, 4);
    @(negedge clk); #1;
    checkOutput("wait_ack_cyc", wb.cyc, 1);
    rst_n = 1'b0;
    #1;
    checkResetValues();
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    checkOutput("ready_after_reset", cmd_ready_o, 1);

    // READ_RESET completes with one write and no RY wait.
    $display("[TB] read reset after reset");
    expectWrite(26'h0000042, 16'h00F0, 0);
    exp_done.push_back(1'b0);
    expected_dones++;
    applyStimulus(2'b00, 26'h0000042, 16'h0000);
    waitIdle(50);
    repeat (10) @(negedge clk);
    #1;
    checkOutput("done_total", done_seen, expected_dones);

    $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
    $finish;
  end

endmodule
